// File: rtl/axi4_sched_pkg.sv
// axi4_sched_pkg: shared types, constants and the circular priority pick for the AXI schedulers.
package axi4_sched_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [3:0] QOS_MAX = 4'd15;
  localparam int MAX_M = 4;
  localparam int MIDX_W = 2;
  // Returns the first set bit of vec at or after ptr, wrapping within the low n bits.
  function automatic logic [MIDX_W-1:0] first_set_from(input logic [MAX_M-1:0] vec, input logic [MIDX_W-1:0] ptr, input int n);
    logic [MIDX_W-1:0] pick;
    logic found;
    int j;
    pick = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_M; i++) begin
      j = (int'(ptr) + i) % n;
      if (i < n && !found && vec[j[MIDX_W-1:0]]) begin
        pick = j[MIDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/axi4_wr_sched_if.sv
// axi4_wr_sched_if: request/handshake inputs and grant/ownership outputs of the write scheduler.
interface axi4_wr_sched_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int IDX_W = $clog2(NUM_MASTERS),
  parameter int OUT_W = $clog2(MAX_OUTSTANDING + 1)
);
  logic [NUM_MASTERS-1:0] aw_req;
  logic [4*NUM_MASTERS-1:0] aw_qos;
  logic aw_hs;
  logic w_last_hs;
  logic b_hs;
  logic [NUM_MASTERS-1:0] aw_grant;
  logic [IDX_W-1:0] aw_grant_idx;
  logic w_owner_vld;
  logic [IDX_W-1:0] w_owner_idx;
  logic [OUT_W-1:0] outstanding;
  logic protocol_err;
  modport master (output aw_req, aw_qos, aw_hs, w_last_hs, b_hs,
                  input aw_grant, aw_grant_idx, w_owner_vld, w_owner_idx, outstanding, protocol_err);
  modport slave (input aw_req, aw_qos, aw_hs, w_last_hs, b_hs,
                 output aw_grant, aw_grant_idx, w_owner_vld, w_owner_idx, outstanding, protocol_err);
endinterface

// File: rtl/axi4_sched_fifo.sv
// axi4_sched_fifo: small synchronous FIFO of master indices with full/empty flags.
module axi4_sched_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
    head = mem_q[rd_q];
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = wr_q + PW'(do_push);
    rd_d = rd_q + PW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge aclk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/axi4_wr_sched.sv
// axi4_wr_sched: QoS/ageing/round-robin AW arbiter with in-order W ownership and an outstanding-write cap.
module axi4_wr_sched
  import axi4_sched_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int AGE_LIMIT = 15,
  parameter int IDX_W = $clog2(NUM_MASTERS)
) (
  input logic aclk,
  input logic aresetn,
  axi4_wr_sched_if.slave bus
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  state_t state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, cand;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d, rr_q, rr_d, win, head;
  logic [3:0] age_q [NUM_MASTERS];
  logic [3:0] age_d [NUM_MASTERS];
  logic [3:0] eff [NUM_MASTERS];
  logic [3:0] best;
  logic [OUT_W-1:0] out_q, out_d;
  logic err_q, err_d;
  logic fifo_full, fifo_empty, push, dec, decide;
  always_comb begin
    best = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      eff[m] = (age_q[m] == 4'(AGE_LIMIT)) ? QOS_MAX : bus.aw_qos[4*m +: 4];
      if (bus.aw_req[m] && eff[m] > best) best = eff[m];
    end
    for (int m = 0; m < NUM_MASTERS; m++) cand[m] = bus.aw_req[m] && eff[m] == best;
    win = IDX_W'(first_set_from(MAX_M'(cand), MIDX_W'(rr_q), NUM_MASTERS));
  end
  always_comb begin
    push = state_q == GRANT && bus.aw_hs;
    dec = bus.b_hs && out_q != '0;
    decide = state_q == IDLE && |bus.aw_req && out_q < OUT_W'(MAX_OUTSTANDING) && !fifo_full;
    state_d = decide ? GRANT : push ? IDLE : state_q;
    grant_d = decide ? NUM_MASTERS'(1) << win : push ? '0 : grant_q;
    grant_idx_d = decide ? win : push ? '0 : grant_idx_q;
    rr_d = !decide ? rr_q : (int'(win) == NUM_MASTERS - 1) ? '0 : win + 1'b1;
    // Losing requesters age toward AGE_LIMIT so low-QoS masters cannot starve.
    for (int m = 0; m < NUM_MASTERS; m++)
      age_d[m] = !decide ? age_q[m] : (IDX_W'(m) == win) ? 4'd0 : !bus.aw_req[m] ? age_q[m] :
                 (age_q[m] == 4'(AGE_LIMIT)) ? age_q[m] : age_q[m] + 4'd1;
    out_d = out_q + OUT_W'(push) - OUT_W'(dec);
    err_d = err_q | (bus.w_last_hs & fifo_empty) | (bus.b_hs & out_q == '0) | (bus.aw_hs & state_q == IDLE);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      grant_idx_q <= '0;
      rr_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
      for (int m = 0; m < NUM_MASTERS; m++) age_q[m] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_q <= rr_d;
      out_q <= out_d;
      err_q <= err_d;
      for (int m = 0; m < NUM_MASTERS; m++) age_q[m] <= age_d[m];
    end
  axi4_sched_fifo #(.W(IDX_W), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .aclk(aclk), .aresetn(aresetn), .push(push), .pop(bus.w_last_hs), .din(grant_idx_q),
    .head(head), .full(fifo_full), .empty(fifo_empty)
  );
  assign bus.aw_grant = grant_q;
  assign bus.aw_grant_idx = grant_idx_q;
  assign bus.w_owner_vld = !fifo_empty;
  assign bus.w_owner_idx = head;
  assign bus.outstanding = out_q;
  assign bus.protocol_err = err_q;
endmodule
